// File: rtl/johnson_ring_decoder_6bit.sv
// Decodes a 6-bit twisted-ring (Johnson) word to its position 0..11 and tracks
// whether successive samples follow the ring sequence (IDLE -> HUNT -> LOCKED).
module johnson_ring_decoder_6bit #(
    parameter int LOCK_RUN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [5:0] code,
    output logic [3:0] index,
    output logic       legal,
    output logic       locked,
    output logic       seq_err,
    output logic       code_err,
    output logic       wrap,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_RUN_W = 4'(LOCK_RUN);

    // Position k: k ones shifted in from the top for k<=6, then zeros for k>6.
    function automatic logic [5:0] johnson_word(input int k);
        logic [5:0] w;
        w = '0;
        for (int b = 0; b < 6; b++) begin
            if (k <= 6) w[b] = (b >= 6 - k);
            else        w[b] = (b < 12 - k);
        end
        return w;
    endfunction

    logic [11:0] hit;
    logic [3:0]  index_dec;
    logic        is_legal;
    logic        in_seq;

    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_match
            localparam logic [5:0] WORD = johnson_word(gi);
            assign hit[gi] = (code == WORD);
        end
    endgenerate

    always_comb begin
        index_dec = 4'hF;
        for (int k = 0; k < 12; k++) begin
            if (hit[k]) index_dec = 4'(k);
        end
    end

    state_t     state_reg, state_next;
    logic [3:0] run_reg, run_next;
    logic [5:0] prev_reg, prev_next;
    logic [3:0] index_reg, index_next;
    logic       legal_reg, legal_next;
    logic       seq_err_reg, seq_err_next;
    logic       code_err_reg, code_err_next;
    logic       wrap_reg, wrap_next;
    logic [7:0] err_count_reg, err_count_next;

    assign is_legal = |hit;
    assign in_seq   = (code == {~prev_reg[0], prev_reg[5:1]});

    always_comb begin
        state_next     = state_reg;
        run_next       = run_reg;
        prev_next      = prev_reg;
        index_next     = index_reg;
        legal_next     = legal_reg;
        seq_err_next   = 1'b0;
        code_err_next  = 1'b0;
        wrap_next      = 1'b0;
        err_count_next = err_count_reg;
        if (valid) begin
            index_next    = index_dec;
            legal_next    = is_legal;
            code_err_next = ~is_legal;
            case (state_reg)
                IDLE: begin
                    if (is_legal) begin
                        state_next = HUNT;
                        run_next   = 4'd1;
                        prev_next  = code;
                    end
                end
                HUNT: begin
                    if (in_seq) begin
                        run_next  = run_reg + 4'd1;
                        prev_next = code;
                        if (run_reg + 4'd1 == LOCK_RUN_W) state_next = LOCKED;
                    end else if (is_legal) begin
                        run_next  = 4'd1;
                        prev_next = code;
                    end else begin
                        state_next = IDLE;
                        run_next   = 4'd0;
                    end
                end
                LOCKED: begin
                    if (in_seq) begin
                        prev_next = code;
                        wrap_next = (prev_reg == 6'b000001);
                    end else begin
                        seq_err_next = 1'b1;
                        if (is_legal) begin
                            state_next = HUNT;
                            run_next   = 4'd1;
                            prev_next  = code;
                        end else begin
                            state_next = IDLE;
                            run_next   = 4'd0;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    run_next   = 4'd0;
                end
            endcase
            // One count per bad sample even when both error flags fire.
            if ((seq_err_next || code_err_next) && err_count_reg != 8'hFF)
                err_count_next = err_count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            run_reg       <= 4'd0;
            prev_reg      <= 6'd0;
            index_reg     <= 4'd0;
            legal_reg     <= 1'b0;
            seq_err_reg   <= 1'b0;
            code_err_reg  <= 1'b0;
            wrap_reg      <= 1'b0;
            err_count_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= run_next;
            prev_reg      <= prev_next;
            index_reg     <= index_next;
            legal_reg     <= legal_next;
            seq_err_reg   <= seq_err_next;
            code_err_reg  <= code_err_next;
            wrap_reg      <= wrap_next;
            err_count_reg <= err_count_next;
        end
    end

    assign index     = index_reg;
    assign legal     = legal_reg;
    assign locked    = (state_reg == LOCKED);
    assign seq_err   = seq_err_reg;
    assign code_err  = code_err_reg;
    assign wrap      = wrap_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_johnson_ring_decoder_6bit.sv
// Table-driven directed bench for the Johnson decoder, plus a saturation and
// gap sequence checked against a small saturating-counter model.
module tb_johnson_ring_decoder_6bit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic [5:0] code = 6'd0;
    logic [3:0] index;
    logic       legal;
    logic       locked;
    logic       seq_err;
    logic       code_err;
    logic       wrap;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    johnson_ring_decoder_6bit #(.LOCK_RUN(3)) dut (
        .clk(clk),
        .rst(rst),
        .valid(valid),
        .code(code),
        .index(index),
        .legal(legal),
        .locked(locked),
        .seq_err(seq_err),
        .code_err(code_err),
        .wrap(wrap),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [5:0] code;
        logic [3:0] idx;
        logic       lg;
        logic       lk;
        logic       se;
        logic       ce;
        logic       wr;
        logic [7:0] ec;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    task automatic check(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic [5:0] c);
        @(negedge clk);
        rst   = r;
        valid = v;
        code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int row, input vec_t e);
        check("index",     row, {4'd0, index},    {4'd0, e.idx});
        check("legal",     row, {7'd0, legal},    {7'd0, e.lg});
        check("locked",    row, {7'd0, locked},   {7'd0, e.lk});
        check("seq_err",   row, {7'd0, seq_err},  {7'd0, e.se});
        check("code_err",  row, {7'd0, code_err}, {7'd0, e.ce});
        check("wrap",      row, {7'd0, wrap},     {7'd0, e.wr});
        check("err_count", row, err_count,        e.ec);
    endtask

    initial begin
        int exp_ec;
        //                rst   valid code       idx    lg    lk    se    ce    wr    ec
        vecs[0]  = '{1'b1, 1'b1, 6'b011111, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 6'b100000, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 6'b110000, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 6'b111000, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 6'b101010, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 6'b111110, 4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 1'b1, 6'b111111, 4'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 6'b011111, 4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 1'b1, 6'b001111, 4'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 6'b000111, 4'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 1'b1, 6'b000011, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[11] = '{1'b0, 1'b1, 6'b000001, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[12] = '{1'b0, 1'b1, 6'b000000, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[13] = '{1'b0, 1'b1, 6'b100000, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[14] = '{1'b0, 1'b0, 6'b000000, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[15] = '{1'b0, 1'b1, 6'b101010, 4'hF,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
        vecs[16] = '{1'b0, 1'b1, 6'b010101, 4'hF,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3};
        vecs[17] = '{1'b0, 1'b1, 6'b000000, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
        vecs[18] = '{1'b0, 1'b1, 6'b100000, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
        vecs[19] = '{1'b0, 1'b1, 6'b110000, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
        vecs[20] = '{1'b1, 1'b1, 6'b011111, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[21] = '{1'b0, 1'b1, 6'b111000, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[22] = '{1'b0, 1'b1, 6'b000011, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[23] = '{1'b0, 1'b1, 6'b000001, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[24] = '{1'b0, 1'b1, 6'b110011, 4'hF,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[25] = '{1'b0, 1'b1, 6'b000001, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[26] = '{1'b0, 1'b1, 6'b000000, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[27] = '{1'b0, 1'b1, 6'b100000, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].rst, vecs[i].valid, vecs[i].code);
            $display("step %0d rst=%0b valid=%0b code=%b -> index=%0h legal=%0b locked=%0b seq_err=%0b code_err=%0b wrap=%0b err_count=%0d",
                     i, vecs[i].rst, vecs[i].valid, vecs[i].code, index, legal, locked,
                     seq_err, code_err, wrap, err_count);
            check_all(i, vecs[i]);
        end

        // Locked here with err_count=1; stream 300 illegal words with idle gaps.
        exp_ec = 1;
        for (int n = 0; n < 300; n++) begin
            apply(1'b0, 1'b1, (n % 2 == 0) ? 6'b101010 : 6'b010110);
            exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
            $display("illegal %0d code_err=%0b seq_err=%0b err_count=%0d", n, code_err, seq_err, err_count);
            check("sat_count", 100 + n, err_count, 8'(exp_ec));
            check("sat_code_err", 100 + n, {7'd0, code_err}, 8'd1);
            check("sat_seq_err", 100 + n, {7'd0, seq_err}, (n == 0) ? 8'd1 : 8'd0);
            check("sat_index", 100 + n, {4'd0, index}, 8'h0F);
            if (n % 50 == 25) begin
                apply(1'b0, 1'b0, 6'b000000);
                $display("gap %0d code_err=%0b err_count=%0d", n, code_err, err_count);
                check("gap_code_err", 100 + n, {7'd0, code_err}, 8'd0);
                check("gap_count", 100 + n, err_count, 8'(exp_ec));
                check("gap_index", 100 + n, {4'd0, index}, 8'h0F);
                check("gap_locked", 100 + n, {7'd0, locked}, 8'd0);
            end
        end

        // A legal word after saturation still decodes and leaves the count pinned.
        apply(1'b0, 1'b1, 6'b111100);
        $display("post-sat code=111100 index=%0h legal=%0b err_count=%0d", index, legal, err_count);
        check("post_index", 500, {4'd0, index}, 8'd4);
        check("post_legal", 500, {7'd0, legal}, 8'd1);
        check("post_count", 500, err_count, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_ring_decoder_6bit.md
JOHNSON_RING_DECODER_6BIT -- requirements
Module: johnson_ring_decoder_6bit

Interface
REQ-001 SHALL have parameter: LOCK_RUN, 3, consecutive in-sequence legal samples needed to lock (legal range 2..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: valid  input  1  sample strobe; code is consumed only on cycles with valid=1.
REQ-005 SHALL have port: code  input  6  observed Johnson word from a right-shifting twisted-ring register (new MSB = ~old bit 0).
REQ-006 SHALL have port: index  output  4  registered decoded position 0..11; 4'hF for an illegal word.
REQ-007 SHALL have port: legal  output  1  registered; 1 if the last sampled word is one of the 12 legal codes.
REQ-008 SHALL have port: locked  output  1  high while the FSM is in LOCKED.
REQ-009 SHALL have port: seq_err  output  1  one-cycle pulse on a sequence break while LOCKED.
REQ-010 SHALL have port: code_err  output  1  one-cycle pulse when an illegal word is sampled.
REQ-011 SHALL have port: wrap  output  1  one-cycle pulse when LOCKED and index advances 11 -> 0.
REQ-012 SHALL have port: err_count  output  8  saturating error counter.

Function
REQ-013 SHALL decode legal words: 000000=0, 100000=1, 110000=2, 111000=3, 111100=4, 111110=5, 111111=6, 011111=7, 001111=8, 000111=9, 000011=10, 000001=11; the other 52 words are illegal.
REQ-014 SHALL define the expected successor of prev as {~prev[0], prev[5:1]}.
REQ-015 SHALL register index/legal one cycle after a valid sample; with valid=0, index, legal, state, prev and run count SHALL hold, and all pulses SHALL be 0.
REQ-016 SHALL implement FSM states IDLE, HUNT, LOCKED, with a 4-bit run counter and a 6-bit prev register.
REQ-017 IDLE: valid & legal -> HUNT, run=1, prev=code; valid & illegal -> stay IDLE.
REQ-018 HUNT: valid & code==succ(prev) -> run+1, prev=code; when run+1==LOCK_RUN -> LOCKED in the same update.
REQ-019 HUNT: valid & legal & code!=succ(prev) -> stay HUNT, run=1, prev=code; valid & illegal -> IDLE, run=0.
REQ-020 LOCKED: valid & code==succ(prev) -> stay LOCKED, prev=code.
REQ-021 LOCKED: valid & code!=succ(prev) -> seq_err=1; next state HUNT (run=1, prev=code) if legal, IDLE (run=0) if illegal.
REQ-022 SHALL pulse code_err on every illegal sample in any state; seq_err and code_err SHALL both assert on an illegal sample in LOCKED.
REQ-023 SHALL increment err_count by exactly 1 per sample with seq_err or code_err (not 2 when both); it saturates at 255 with no wrap.
REQ-024 SHALL assert wrap only on an in-sequence sample in LOCKED whose prev index is 11 and new index is 0.
REQ-025 SHALL assert all pulses in the same cycle the corresponding index/legal update becomes visible.

Reset
REQ-026 SHALL, on rst=1 at posedge clk, set: state=IDLE, run=0, prev=000000, index=0, legal=0, locked=0, seq_err=0, code_err=0, wrap=0, err_count=0.
REQ-027 rst SHALL take priority over a simultaneous valid; the sample in that cycle is discarded, including mid-lock.

Verification
REQ-028 Reset, then valid every cycle with 100000,110000,111000 -> index 1,2,3; locked=1 one cycle after the third sample; err_count=0.
REQ-029 Locked stream ...000011,000001,000000 -> index 10,11,0; wrap=1 exactly on the index-0 cycle; seq_err=0.
REQ-030 Locked at 111000, then 111110 (legal, skipped 111100) -> seq_err=1 one cycle, locked=0, state HUNT, err_count=1; next 111111,011111 -> relock.
REQ-031 Locked, then 101010 -> code_err=1 and seq_err=1 same cycle, index=4'hF, legal=0, state IDLE, err_count+1 only.
REQ-032 300 consecutive illegal samples -> err_count stops at 255; valid=0 gaps mid-stream -> no state change, no pulses.
REQ-033 rst=1 while LOCKED and valid=1 with 011111 -> all outputs to reset values next cycle; the sample is ignored.
